v_usampler_1ppc: RTL and testbench

AXI4-Stream video 2x upsampler, one pixel per clock, the expansion counterpart of the 2:1 video down-sampler in the same video pipeline. Horizontal upsampling by pixel replication (each input pixel emitted twice); vertical upsampling by line replication (each completed line replayed from an internal line buffer). Sits between a reduced-resolution processing stage and a full-resolution sink such as the VDMA or video-out path. Either axis can be disabled by parameter.

---
 rtl/v_usampler_1ppc_if.sv | 19 +
 rtl/v_usampler_1ppc.sv | 206 ++++++++++++++++++++
 tb/tb_v_usampler_1ppc.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_usampler_1ppc_if.sv
// v_usampler_1ppc_if
// AXI4-Stream video beat bundle used on both sides of the 2x upsampler.
//   tvalid : beat valid              (master -> slave)
//   tready : beat accept             (slave  -> master)
//   tdata  : one pixel, PIXEL_WIDTH  (master -> slave)
//   tlast  : end of line             (master -> slave)
//   tuser  : start of frame          (master -> slave)
interface v_usampler_1ppc_if #(
  parameter int unsigned PIXEL_WIDTH = 24
);
  logic                   tvalid;
  logic                   tready;
  logic [PIXEL_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/v_usampler_1ppc.sv
// v_usampler_1ppc
// AXI4-Stream 2x video upsampler, one pixel per clock.
//   Horizontal: each input pixel is emitted twice (COLUMN_UP).
//   Vertical:   each completed line is replayed once from a line buffer (LINE_UP).
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   s_axis       : input pixel stream (slave modport)
//   m_axis       : output pixel stream, fully registered (master modport)
//   line_ovf     : one-cycle pulse after a line longer than MAX_IN_WIDTH ends
module v_usampler_1ppc #(
  parameter bit          COLUMN_UP    = 1'b1,
  parameter bit          LINE_UP      = 1'b1,
  parameter int unsigned PIXEL_WIDTH  = 24,
  parameter int unsigned MAX_IN_WIDTH = 1920,
  parameter int unsigned ADDR_WIDTH   = 11
) (
  input  logic                    aclk,
  input  logic                    areset,
  v_usampler_1ppc_if.slave        s_axis,
  v_usampler_1ppc_if.master       m_axis,
  output logic                    line_ovf
);

  // One extra bit so the write pointer can reach MAX_IN_WIDTH and flag overflow.
  localparam int unsigned     CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]   MAX_W = CW'(MAX_IN_WIDTH);

  typedef enum logic {LIVE, REPLAY} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          wr_addr_q, wr_addr_d;
  logic [CW-1:0]          rd_addr_q, rd_addr_d;
  logic [CW-1:0]          line_len_q, line_len_d;
  logic                   phase_q, phase_d;
  logic                   last_q, last_d;
  logic                   pf_valid_q, pf_valid_d;
  logic                   m_valid_q, m_valid_d;
  logic [PIXEL_WIDTH-1:0] m_data_q, m_data_d;
  logic                   m_last_q, m_last_d;
  logic                   m_user_q, m_user_d;
  logic                   ovf_q, ovf_d;

  logic                   out_free;
  logic                   s_ready;
  logic                   accept;
  logic [CW-1:0]          wr_idx;
  logic [CW-1:0]          wr_next;
  logic                   end_line;
  logic [CW-1:0]          end_len;

  logic                   ram_we;
  logic                   ram_re;
  logic [ADDR_WIDTH-1:0]  ram_waddr;
  logic [ADDR_WIDTH-1:0]  ram_raddr;
  logic [PIXEL_WIDTH-1:0] ram_rdata_q;
  logic [PIXEL_WIDTH-1:0] mem [MAX_IN_WIDTH];

  always_comb begin
    out_free = !m_valid_q || m_axis.tready;
    s_ready  = !areset && (state_q == LIVE) && out_free && !phase_q;
    accept   = s_ready && s_axis.tvalid;
    // A start-of-frame pixel restarts the line, discarding any partial one.
    wr_idx   = s_axis.tuser ? '0 : wr_addr_q;
    // Saturate at MAX_W: the pointer doubles as the clamped line length.
    wr_next  = (wr_idx < MAX_W) ? wr_idx + 1'b1 : wr_idx;

    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    line_len_d = line_len_q;
    phase_d    = phase_q;
    last_d     = last_q;
    pf_valid_d = pf_valid_q;
    m_valid_d  = m_valid_q && !m_axis.tready;
    m_data_d   = m_data_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;
    ovf_d      = 1'b0;
    end_line   = 1'b0;
    end_len    = wr_addr_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = wr_idx[ADDR_WIDTH-1:0];
    ram_raddr  = rd_addr_q[ADDR_WIDTH-1:0];

    case (state_q)
      LIVE: begin
        if (accept) begin
          ram_we    = (wr_idx < MAX_W);
          wr_addr_d = wr_next;
          m_valid_d = 1'b1;
          m_data_d  = s_axis.tdata;
          m_user_d  = s_axis.tuser;
          m_last_d  = s_axis.tlast && !COLUMN_UP;
          ovf_d     = s_axis.tlast && (wr_idx >= MAX_W);
          if (COLUMN_UP) begin
            phase_d = 1'b1;
            last_d  = s_axis.tlast;
          end else if (s_axis.tlast) begin
            end_line = 1'b1;
            end_len  = wr_next;
          end
        end else if (phase_q && out_free) begin
          // Duplicate beat: the output register still holds the original pixel.
          m_valid_d = 1'b1;
          m_user_d  = 1'b0;
          m_last_d  = last_q;
          phase_d   = 1'b0;
          if (last_q) begin
            end_line = 1'b1;
            end_len  = wr_addr_q;
          end
        end
        if (end_line) begin
          line_len_d = end_len;
          if (LINE_UP) begin
            state_d    = REPLAY;
            rd_addr_d  = '0;
            pf_valid_d = 1'b0;
          end else begin
            wr_addr_d = '0;
          end
        end
      end

      REPLAY: begin
        // rd_addr_q is the next address to read; ram_rdata_q holds pixel rd_addr_q-1.
        if (!pf_valid_q) begin
          ram_re     = 1'b1;
          rd_addr_d  = rd_addr_q + 1'b1;
          pf_valid_d = 1'b1;
        end else if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = ram_rdata_q;
          m_user_d  = 1'b0;
          m_last_d  = 1'b0;
          if (COLUMN_UP && !phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (rd_addr_q == line_len_q) begin
              m_last_d   = 1'b1;
              state_d    = LIVE;
              wr_addr_d  = '0;
              pf_valid_d = 1'b0;
            end else begin
              // Fetch the next pixel now so it is ready when this beat drains.
              ram_re    = 1'b1;
              rd_addr_d = rd_addr_q + 1'b1;
            end
          end
        end
      end

      default: state_d = LIVE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= LIVE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      line_len_q <= '0;
      phase_q    <= 1'b0;
      last_q     <= 1'b0;
      pf_valid_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      m_user_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      line_len_q <= line_len_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      pf_valid_q <= pf_valid_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
      ovf_q      <= ovf_d;
    end
  end

  // Line buffer: simple dual-port, synchronous read.
  always_ff @(posedge aclk) begin
    if (ram_we) begin
      mem[ram_waddr] <= s_axis.tdata;
    end
    if (ram_re) begin
      ram_rdata_q <= mem[ram_raddr];
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tlast  = m_last_q;
  assign m_axis.tuser  = m_user_q;
  assign line_ovf      = ovf_q;

endmodule

// File: tb/tb_v_usampler_1ppc.sv
// Testbench for v_usampler_1ppc. Three instances share one clock:
//   dut 0: both axes up, 8-pixel line buffer
//   dut 1: vertical only, 8-pixel line buffer
//   dut 2: pass-through
module tb_v_usampler_1ppc;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  v_usampler_1ppc_if #(.PIXEL_WIDTH(8)) a_s ();
  v_usampler_1ppc_if #(.PIXEL_WIDTH(8)) a_m ();
  v_usampler_1ppc_if #(.PIXEL_WIDTH(8)) b_s ();
  v_usampler_1ppc_if #(.PIXEL_WIDTH(8)) b_m ();
  v_usampler_1ppc_if #(.PIXEL_WIDTH(8)) c_s ();
  v_usampler_1ppc_if #(.PIXEL_WIDTH(8)) c_m ();
  logic a_ovf, b_ovf, c_ovf;

  v_usampler_1ppc #(.COLUMN_UP(1'b1), .LINE_UP(1'b1), .PIXEL_WIDTH(8),
                    .MAX_IN_WIDTH(8), .ADDR_WIDTH(3))
    u_a (.aclk(clk), .areset(areset), .s_axis(a_s), .m_axis(a_m), .line_ovf(a_ovf));
  v_usampler_1ppc #(.COLUMN_UP(1'b0), .LINE_UP(1'b1), .PIXEL_WIDTH(8),
                    .MAX_IN_WIDTH(8), .ADDR_WIDTH(3))
    u_b (.aclk(clk), .areset(areset), .s_axis(b_s), .m_axis(b_m), .line_ovf(b_ovf));
  v_usampler_1ppc #(.COLUMN_UP(1'b0), .LINE_UP(1'b0), .PIXEL_WIDTH(8),
                    .MAX_IN_WIDTH(8), .ADDR_WIDTH(3))
    u_c (.aclk(clk), .areset(areset), .s_axis(c_s), .m_axis(c_m), .line_ovf(c_ovf));

  beat_t a_in_q[$], b_in_q[$], c_in_q[$];
  beat_t a_exp_q[$], b_exp_q[$], c_exp_q[$];
  beat_t cur[3];
  bit    have[3];
  bit    gap[3];
  bit    rnd[3];
  bit    hold_v[3];
  beat_t hold_b[3];
  int    b_times[$];
  int    ovf_cnt = 0;
  logic [7:0] ovf_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_in(input int d, input beat_t b);
    case (d)
      0: a_in_q.push_back(b);
      1: b_in_q.push_back(b);
      default: c_in_q.push_back(b);
    endcase
  endfunction

  function automatic void push_exp(input int d, input beat_t b);
    case (d)
      0: a_exp_q.push_back(b);
      1: b_exp_q.push_back(b);
      default: c_exp_q.push_back(b);
    endcase
  endfunction

  function automatic bit pop_in(input int d, output beat_t b);
    pop_in = 1'b0;
    b = '0;
    case (d)
      0: if (a_in_q.size() != 0) begin b = a_in_q.pop_front(); pop_in = 1'b1; end
      1: if (b_in_q.size() != 0) begin b = b_in_q.pop_front(); pop_in = 1'b1; end
      default: if (c_in_q.size() != 0) begin b = c_in_q.pop_front(); pop_in = 1'b1; end
    endcase
  endfunction

  function automatic bit pop_exp(input int d, output beat_t b);
    pop_exp = 1'b0;
    b = '0;
    case (d)
      0: if (a_exp_q.size() != 0) begin b = a_exp_q.pop_front(); pop_exp = 1'b1; end
      1: if (b_exp_q.size() != 0) begin b = b_exp_q.pop_front(); pop_exp = 1'b1; end
      default: if (c_exp_q.size() != 0) begin b = c_exp_q.pop_front(); pop_exp = 1'b1; end
    endcase
  endfunction

  // Reference model: input beats and the expected output sequence for one line.
  task automatic send_line(input int d, input logic [7:0] base, input int n, input bit sof);
    int    reps;
    int    keep;
    beat_t b;
    beat_t e;
    reps = (d == 0) ? 2 : 1;
    keep = (n < 8) ? n : 8;
    for (int i = 0; i < n; i++) begin
      b.data = base + 8'(i);
      b.last = (i == n - 1);
      b.user = sof && (i == 0);
      push_in(d, b);
      for (int r = 0; r < reps; r++) begin
        e.data = b.data;
        e.last = b.last && (r == reps - 1);
        e.user = b.user && (r == 0);
        push_exp(d, e);
      end
    end
    if (d != 2) begin
      for (int i = 0; i < keep; i++) begin
        for (int r = 0; r < reps; r++) begin
          e.data = base + 8'(i);
          e.last = (i == keep - 1) && (r == reps - 1);
          e.user = 1'b0;
          push_exp(d, e);
        end
      end
    end
  endtask

  task automatic drv_next(input int d, input bit fire);
    if (fire) have[d] = 1'b0;
    if (!have[d] && (!gap[d] || ($urandom_range(0, 2) != 0))) have[d] = pop_in(d, cur[d]);
  endtask

  task automatic mon_step(input int d, input logic v, input logic r, input beat_t obs);
    beat_t e;
    if (areset) begin
      hold_v[d] = 1'b0;
      return;
    end
    if (hold_v[d]) check($sformatf("stall_hold%0d", d), 32'({v, obs}), 32'({1'b1, hold_b[d]}));
    if (v && r) begin
      if (d == 1) b_times.push_back(cyc);
      if (!pop_exp(d, e)) check($sformatf("extra_beat%0d", d), 32'(obs), 32'h3ff);
      else check($sformatf("beat%0d", d), 32'(obs), 32'(e));
      hold_v[d] = 1'b0;
    end else begin
      hold_v[d] = v;
      hold_b[d] = obs;
    end
  endtask

  // Drivers: handshake decided mid-cycle, next beat presented just after the edge.
  initial begin
    bit fire;
    a_s.tvalid = 1'b0; a_s.tdata = '0; a_s.tlast = 1'b0; a_s.tuser = 1'b0;
    forever begin
      @(negedge clk);
      fire = a_s.tvalid && a_s.tready;
      @(posedge clk); #1;
      drv_next(0, fire);
      a_s.tvalid = have[0];
      {a_s.tdata, a_s.tlast, a_s.tuser} = cur[0];
    end
  end

  initial begin
    bit fire;
    b_s.tvalid = 1'b0; b_s.tdata = '0; b_s.tlast = 1'b0; b_s.tuser = 1'b0;
    forever begin
      @(negedge clk);
      fire = b_s.tvalid && b_s.tready;
      @(posedge clk); #1;
      drv_next(1, fire);
      b_s.tvalid = have[1];
      {b_s.tdata, b_s.tlast, b_s.tuser} = cur[1];
    end
  end

  initial begin
    bit fire;
    c_s.tvalid = 1'b0; c_s.tdata = '0; c_s.tlast = 1'b0; c_s.tuser = 1'b0;
    forever begin
      @(negedge clk);
      fire = c_s.tvalid && c_s.tready;
      @(posedge clk); #1;
      drv_next(2, fire);
      c_s.tvalid = have[2];
      {c_s.tdata, c_s.tlast, c_s.tuser} = cur[2];
    end
  end

  // Monitors: compare each output handshake against the scoreboard.
  initial begin
    a_m.tready = 1'b0;
    forever begin
      @(negedge clk);
      mon_step(0, a_m.tvalid, a_m.tready, {a_m.tdata, a_m.tlast, a_m.tuser});
      if (a_ovf === 1'b1) begin
        ovf_cnt++;
        ovf_data = a_m.tdata;
      end
      @(posedge clk); #1;
      a_m.tready = rnd[0] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    b_m.tready = 1'b0;
    forever begin
      @(negedge clk);
      mon_step(1, b_m.tvalid, b_m.tready, {b_m.tdata, b_m.tlast, b_m.tuser});
      @(posedge clk); #1;
      b_m.tready = 1'b1;
    end
  end

  initial begin
    bit    prev_fire;
    beat_t prev;
    prev_fire = 1'b0;
    prev = '0;
    c_m.tready = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_fire && !areset)
        check("c_latency", 32'({c_m.tvalid, c_m.tdata, c_m.tlast, c_m.tuser}), 32'({1'b1, prev}));
      prev_fire = c_s.tvalid && c_s.tready && !areset;
      prev = {c_s.tdata, c_s.tlast, c_s.tuser};
      mon_step(2, c_m.tvalid, c_m.tready, {c_m.tdata, c_m.tlast, c_m.tuser});
      @(posedge clk); #1;
      c_m.tready = 1'b1;
    end
  end

  task automatic drain(input string tag);
    int left;
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      left = a_in_q.size() + b_in_q.size() + c_in_q.size() + a_exp_q.size() + b_exp_q.size()
           + c_exp_q.size() + int'(have[0]) + int'(have[1]) + int'(have[2]);
      if (left == 0) break;
    end
    repeat (12) @(negedge clk);
    check(tag, 32'(left), 32'd0);
  endtask

  initial begin
    bit          found;
    logic [17:0] rp;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a", 32'({a_m.tvalid, a_m.tdata, a_m.tlast, a_m.tuser, a_ovf, a_s.tready}), 32'd0);
    check("rst_b", 32'({b_m.tvalid, b_m.tdata, b_m.tlast, b_m.tuser, b_ovf, b_s.tready}), 32'd0);
    check("rst_c", 32'({c_m.tvalid, c_m.tdata, c_m.tlast, c_m.tuser, c_ovf, c_s.tready}), 32'd0);
    #2 areset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst_a", 32'(a_s.tready), 32'd1);
    check("rdy_after_rst_b", 32'(b_s.tready), 32'd1);
    check("rdy_after_rst_c", 32'(c_s.tready), 32'd1);

    // Both up, two 4-pixel lines, tready high, no input gaps
    send_line(0, 8'hA0, 4, 1'b1);
    send_line(0, 8'hE0, 4, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_s.tvalid && a_s.tready) begin
        found = 1'b1;
        break;
      end
    end
    check("a_first_accept", 32'(found), 32'd1);
    rp = '0;
    rp[17] = a_s.tready;
    for (int k = 16; k >= 0; k--) begin
      @(negedge clk);
      rp[k] = a_s.tready;
    end
    check("a_ready_pattern", 32'(rp), 32'(18'b101010100000000001));
    drain("drain_two_lines");

    // Both up, full 8-pixel line, random backpressure and input gaps
    rnd[0] = 1'b1;
    gap[0] = 1'b1;
    send_line(0, 8'h10, 8, 1'b1);
    drain("drain_random_tready");
    rnd[0] = 1'b0;
    gap[0] = 1'b0;
    check("no_ovf_full_line", 32'(ovf_cnt), 32'd0);

    // Vertical only, line [1,2,3]
    b_times.delete();
    send_line(1, 8'h01, 3, 1'b1);
    drain("drain_line_only");
    check("b_beat_count", 32'(b_times.size()), 32'd6);
    if (b_times.size() == 6) begin
      check("b_switch_bubble", 32'(b_times[3] - b_times[2] <= 2), 32'd1);
      check("b_replay_gap1", 32'(b_times[4] - b_times[3]), 32'd1);
      check("b_replay_gap2", 32'(b_times[5] - b_times[4]), 32'd1);
    end

    // Pass-through
    gap[2] = 1'b1;
    send_line(2, 8'h30, 3, 1'b1);
    send_line(2, 8'h40, 2, 1'b0);
    drain("drain_passthrough");

    // Overflow: 10-pixel line into an 8-pixel buffer
    send_line(0, 8'h60, 10, 1'b1);
    drain("drain_overflow");
    check("ovf_count", 32'(ovf_cnt), 32'd1);
    check("ovf_at_tlast", 32'(ovf_data), 32'h69);

    // Reset in the middle of a replay
    send_line(0, 8'h50, 4, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_exp_q.size() <= 5) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_replay", 32'(found), 32'd1);
    #2;
    areset = 1'b1;
    a_in_q.delete();
    a_exp_q.delete();
    have[0] = 1'b0;
    a_s.tvalid = 1'b0;
    @(negedge clk);
    check("mid_replay_rst", 32'({a_m.tvalid, a_m.tdata, a_m.tlast, a_m.tuser, a_ovf, a_s.tready}), 32'd0);
    @(negedge clk);
    #2 areset = 1'b0;
    @(negedge clk);
    check("rdy_after_mid_rst", 32'(a_s.tready), 32'd1);
    send_line(0, 8'hB0, 2, 1'b1);
    drain("drain_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
